// File: rtl/input_port_vc_buffer_pkg.sv
// Shared NoC types and defaults for the input-port VC buffer.
// Optional error checking is enabled by defining INPUT_VC_BUF_ERR_CHK_EN.
package input_port_vc_buffer_pkg;

    localparam int VC_ID_NUM_MAX_W = 1;
    localparam int NodeID_X_Width  = 2;
    localparam int NodeID_Y_Width  = 2;
    localparam int FLIT_PAYLOAD_W  = 256;
    localparam int DEF_VC_NUM      = 2;
    localparam int DEF_VC_DEPTH    = 4;

    typedef logic [FLIT_PAYLOAD_W-1:0] flit_payload_t;

    // Occupancy counter width: must hold 0..depth inclusive.
    function automatic int vc_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/input_port_vc_buffer_if.sv
// Link + switch-allocation bundle of one router input port.
// slave: the VC buffer; master: link sender / SA side.
interface input_port_vc_buffer_if
    import input_port_vc_buffer_pkg::*;
#(
    parameter int VC_NUM   = DEF_VC_NUM,
    parameter int VC_DEPTH = DEF_VC_DEPTH,
    parameter int VC_ID_W  = VC_ID_NUM_MAX_W,
    parameter int FLIT_W   = FLIT_PAYLOAD_W
);
    localparam int CNT_W = vc_cnt_w(VC_DEPTH);

    logic                      rx_flit_v_i;
    logic [FLIT_W-1:0]         rx_flit_i;
    logic [VC_ID_W-1:0]        rx_flit_vc_id_i;
    logic                      rx_lcrd_v_o;
    logic [VC_ID_W-1:0]        rx_lcrd_id_o;
    logic                      sa_rd_en_i;
    logic [VC_ID_W-1:0]        sa_rd_vc_id_i;
    logic [VC_NUM-1:0]         vc_head_v_o;
    logic [VC_NUM*FLIT_W-1:0]  vc_head_flit_o;
    logic [VC_NUM*CNT_W-1:0]   vc_cnt_o;
    logic                      err_ovf_o;
    logic                      err_udf_o;

    modport slave (
        input  rx_flit_v_i, rx_flit_i, rx_flit_vc_id_i, sa_rd_en_i, sa_rd_vc_id_i,
        output rx_lcrd_v_o, rx_lcrd_id_o, vc_head_v_o, vc_head_flit_o, vc_cnt_o,
               err_ovf_o, err_udf_o
    );

    modport master (
        output rx_flit_v_i, rx_flit_i, rx_flit_vc_id_i, sa_rd_en_i, sa_rd_vc_id_i,
        input  rx_lcrd_v_o, rx_lcrd_id_o, vc_head_v_o, vc_head_flit_o, vc_cnt_o,
               err_ovf_o, err_udf_o
    );

endinterface

// File: rtl/input_port_vc_buffer_vc_fifo.sv
// Single VC FIFO: storage, wrapping pointers, occupancy and full/empty.
// push/pop arrive already qualified by the parent (never push when full
// without a pop, never pop when empty).
module input_port_vc_buffer_vc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               din_i,
    output logic [W-1:0]               head_o,
    output logic [$clog2(DEPTH):0]     cnt_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_i) mem[wr_ptr_q] <= din_i;
    end

    // Next pointers and count; power-of-two depth makes pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer/count state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Head is read straight from storage: a write shows up the next cycle.
    assign head_o  = mem[rd_ptr_q];
    assign cnt_o   = cnt_q;
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/input_port_vc_buffer.sv
// Per-input-port VC flit buffer: one FIFO per VC, head flits to SA,
// one link credit returned per successful pop.
// Sticky error flags and assertions exist only with INPUT_VC_BUF_ERR_CHK_EN.
module input_port_vc_buffer
    import input_port_vc_buffer_pkg::*;
#(
    parameter int VC_NUM   = DEF_VC_NUM,
    parameter int VC_DEPTH = DEF_VC_DEPTH,
    parameter int VC_ID_W  = VC_ID_NUM_MAX_W,
    parameter int FLIT_W   = FLIT_PAYLOAD_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input_port_vc_buffer_if.slave bus
);
    localparam int CNT_W = vc_cnt_w(VC_DEPTH);

    logic                  wr_id_ok;
    logic                  rd_id_ok;
    logic [VC_NUM-1:0]     push_req, push_ok;
    logic [VC_NUM-1:0]     pop_req, pop_ok;
    logic [VC_NUM-1:0]     vc_full, vc_empty;
    logic                  lcrd_v_q, lcrd_v_d;
    logic [VC_ID_W-1:0]    lcrd_id_q, lcrd_id_d;

    // Ids beyond the configured VC count address nothing.
    assign wr_id_ok = (32'(bus.rx_flit_vc_id_i) < 32'(VC_NUM));
    assign rd_id_ok = (32'(bus.sa_rd_vc_id_i) < 32'(VC_NUM));

    for (genvar gi = 0; gi < VC_NUM; gi++) begin : g_vc
        assign push_req[gi] = bus.rx_flit_v_i && wr_id_ok
                              && (bus.rx_flit_vc_id_i == VC_ID_W'(gi));
        assign pop_req[gi]  = bus.sa_rd_en_i && rd_id_ok
                              && (bus.sa_rd_vc_id_i == VC_ID_W'(gi));
        // A pop on an empty VC is ignored; a push to a full VC only lands
        // when the same VC is popped in the same cycle.
        assign pop_ok[gi]   = pop_req[gi] && !vc_empty[gi];
        assign push_ok[gi]  = push_req[gi] && (!vc_full[gi] || pop_ok[gi]);

        input_port_vc_buffer_vc_fifo #(
            .DEPTH (VC_DEPTH),
            .W     (FLIT_W)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push_ok[gi]),
            .pop_i   (pop_ok[gi]),
            .din_i   (bus.rx_flit_i),
            .head_o  (bus.vc_head_flit_o[gi*FLIT_W +: FLIT_W]),
            .cnt_o   (bus.vc_cnt_o[gi*CNT_W +: CNT_W]),
            .full_o  (vc_full[gi]),
            .empty_o (vc_empty[gi])
        );

        assign bus.vc_head_v_o[gi] = !vc_empty[gi];
    end

    // Credit for the VC that was actually popped; id holds between credits.
    always_comb begin
        lcrd_v_d  = |pop_ok;
        lcrd_id_d = lcrd_id_q;
        if (|pop_ok) lcrd_id_d = bus.sa_rd_vc_id_i;
    end

    // Credit return register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcrd_v_q  <= 1'b0;
            lcrd_id_q <= '0;
        end else begin
            lcrd_v_q  <= lcrd_v_d;
            lcrd_id_q <= lcrd_id_d;
        end
    end

    assign bus.rx_lcrd_v_o  = lcrd_v_q;
    assign bus.rx_lcrd_id_o = lcrd_id_q;

`ifdef INPUT_VC_BUF_ERR_CHK_EN
    logic ovf_evt, udf_evt;
    logic err_ovf_q, err_ovf_d;
    logic err_udf_q, err_udf_d;

    // Illegal write (bad id or full VC without pop) / illegal pop (bad id or empty VC).
    always_comb begin
        ovf_evt   = bus.rx_flit_v_i && (!wr_id_ok || (|(push_req & ~push_ok)));
        udf_evt   = bus.sa_rd_en_i  && (!rd_id_ok || (|(pop_req & ~pop_ok)));
        err_ovf_d = err_ovf_q | ovf_evt;
        err_udf_d = err_udf_q | udf_evt;
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    // Simulation notice on each illegal event.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!ovf_evt) else $warning("input_port_vc_buffer: write to full/invalid VC");
            assert (!udf_evt) else $warning("input_port_vc_buffer: pop of empty/invalid VC");
        end
    end

    assign bus.err_ovf_o = err_ovf_q;
    assign bus.err_udf_o = err_udf_q;
`else
    assign bus.err_ovf_o = 1'b0;
    assign bus.err_udf_o = 1'b0;
`endif

endmodule

// File: tb/tb_input_port_vc_buffer.sv
// Self-checking bench for input_port_vc_buffer: directed scenarios plus
// random traffic, compared against a per-VC queue model.
module tb_input_port_vc_buffer;
    import input_port_vc_buffer_pkg::*;

    localparam int VC_NUM   = 2;
    localparam int VC_DEPTH = 4;
    localparam int VC_ID_W  = 1;
    localparam int FLIT_W   = 256;
    localparam int CNT_W    = 3;
`ifdef INPUT_VC_BUF_ERR_CHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    input_port_vc_buffer_if #(
        .VC_NUM(VC_NUM), .VC_DEPTH(VC_DEPTH), .VC_ID_W(VC_ID_W), .FLIT_W(FLIT_W)
    ) bus ();

    input_port_vc_buffer #(
        .VC_NUM(VC_NUM), .VC_DEPTH(VC_DEPTH), .VC_ID_W(VC_ID_W), .FLIT_W(FLIT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_cyc  = 0;

    // Reference model: a plain queue per VC plus expected credit / flags.
    logic [FLIT_W-1:0]  mq [VC_NUM][$];
    logic               m_lcrd_v;
    logic [VC_ID_W-1:0] m_lcrd_id;
    logic               m_ovf, m_udf;

    task automatic check_eq(input string tag, input logic [FLIT_W-1:0] got,
                            input logic [FLIT_W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < VC_NUM; v++) mq[v].delete();
        m_lcrd_v  = 1'b0;
        m_lcrd_id = '0;
        m_ovf     = 1'b0;
        m_udf     = 1'b0;
    endtask

    task automatic drive_idle();
        bus.rx_flit_v_i     = 1'b0;
        bus.rx_flit_i       = '0;
        bus.rx_flit_vc_id_i = '0;
        bus.sa_rd_en_i      = 1'b0;
        bus.sa_rd_vc_id_i   = '0;
    endtask

    task automatic check_state(input string tag);
        for (int v = 0; v < VC_NUM; v++) begin
            check_eq({tag, "_head_v"}, FLIT_W'(bus.vc_head_v_o[v]), FLIT_W'(mq[v].size() != 0));
            check_eq({tag, "_cnt"}, FLIT_W'(bus.vc_cnt_o[v*CNT_W +: CNT_W]), FLIT_W'(mq[v].size()));
            if (mq[v].size() != 0)
                check_eq({tag, "_head_flit"}, bus.vc_head_flit_o[v*FLIT_W +: FLIT_W], mq[v][0]);
        end
        check_eq({tag, "_lcrd_v"}, FLIT_W'(bus.rx_lcrd_v_o), FLIT_W'(m_lcrd_v));
        if (m_lcrd_v) check_eq({tag, "_lcrd_id"}, FLIT_W'(bus.rx_lcrd_id_o), FLIT_W'(m_lcrd_id));
        check_eq({tag, "_err_ovf"}, FLIT_W'(bus.err_ovf_o), FLIT_W'(m_ovf & ERR_EN));
        check_eq({tag, "_err_udf"}, FLIT_W'(bus.err_udf_o), FLIT_W'(m_udf & ERR_EN));
    endtask

    // One clock of traffic: drive, clock, update model, compare.
    task automatic cycle(input string tag, input bit wv, input int wid,
                         input logic [FLIT_W-1:0] wd, input bit rv, input int rid);
        bit pop_ok, push_ok;
        bus.rx_flit_v_i     = wv;
        bus.rx_flit_vc_id_i = VC_ID_W'(wid);
        bus.rx_flit_i       = wd;
        bus.sa_rd_en_i      = rv;
        bus.sa_rd_vc_id_i   = VC_ID_W'(rid);
        @(posedge clk);
        #1;
        n_cyc++;
        pop_ok  = rv && (mq[rid].size() > 0);
        push_ok = wv && ((mq[wid].size() < VC_DEPTH) || (pop_ok && rid == wid));
        if (wv && !push_ok) m_ovf = 1'b1;
        if (rv && !pop_ok)  m_udf = 1'b1;
        if (pop_ok)  void'(mq[rid].pop_front());
        if (push_ok) mq[wid].push_back(wd);
        m_lcrd_v = pop_ok;
        if (pop_ok) m_lcrd_id = VC_ID_W'(rid);
        drive_idle();
        $display("%s cyc=%0d wr=%0b vc%0d d=%0h rd=%0b vc%0d -> cnt0=%0d cnt1=%0d lcrd=%0b/%0d",
                 tag, n_cyc, wv, wid, wd[31:0], rv, rid, mq[0].size(), mq[1].size(),
                 m_lcrd_v, m_lcrd_id);
        check_state(tag);
    endtask

    function automatic logic [FLIT_W-1:0] rand_flit();
        logic [FLIT_W-1:0] f;
        for (int k = 0; k < FLIT_W/32; k++) f[k*32 +: 32] = $urandom();
        return f;
    endfunction

    // Asynchronous reset asserted between clock edges.
    task automatic mid_cycle_reset(input string tag);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_state({tag, "_async"});
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_state({tag, "_rel"});
    endtask

    initial begin
        drive_idle();
        model_reset();
        rst = 1'b1;
        #1;
        check_state("reset");
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Write then pop one flit on VC1.
        cycle("t2_wr", 1, 1, FLIT_W'(8'hA5), 0, 0);
        check_eq("t2_head_a5", bus.vc_head_flit_o[FLIT_W +: FLIT_W], FLIT_W'(8'hA5));
        cycle("t2_pop", 0, 0, '0, 1, 1);
        check_eq("t2_credit_id", FLIT_W'(bus.rx_lcrd_id_o), FLIT_W'(1));
        cycle("t2_idle", 0, 0, '0, 0, 0);

        // Fill VC0, overflow write dropped, drain in order.
        for (int i = 0; i < 4; i++) cycle("t3_fill", 1, 0, FLIT_W'(i), 0, 0);
        cycle("t3_ovf", 1, 0, FLIT_W'(8'h99), 0, 0);
        check_eq("t3_cnt_full", FLIT_W'(bus.vc_cnt_o[CNT_W-1:0]), FLIT_W'(4));
        for (int i = 0; i < 4; i++) begin
            check_eq("t3_drain", bus.vc_head_flit_o[FLIT_W-1:0], FLIT_W'(i));
            cycle("t3_pop", 0, 0, '0, 1, 0);
        end

        // Full VC0: same-cycle write+pop keeps count, new flit drains last.
        mid_cycle_reset("rst_a");
        for (int i = 0; i < 4; i++) cycle("t4_fill", 1, 0, FLIT_W'(16 + i), 0, 0);
        cycle("t4_wrpop", 1, 0, FLIT_W'(7), 1, 0);
        check_eq("t4_no_ovf", FLIT_W'(bus.err_ovf_o), FLIT_W'(0));
        for (int i = 0; i < 4; i++) cycle("t4_drain", 0, 0, '0, 1, 0);
        check_eq("t4_last_cnt", FLIT_W'(bus.vc_cnt_o[CNT_W-1:0]), FLIT_W'(0));

        // Pop an empty VC1.
        cycle("t5_udf", 0, 0, '0, 1, 1);
        check_eq("t5_no_credit", FLIT_W'(bus.rx_lcrd_v_o), FLIT_W'(0));

        // Interleaved writes and pops across pointer wrap.
        for (int i = 0; i < 8; i++) cycle("t6_mix", 1, i % 2, FLIT_W'(32 + i), i >= 2, i % 2);
        for (int i = 0; i < 4; i++) cycle("t6_tail", 0, 0, '0, 1, i % 2);

        // Random traffic, reset in the middle of it.
        for (int i = 0; i < 300; i++) begin
            cycle("rnd", $urandom_range(0, 99) < 60, $urandom_range(0, VC_NUM-1), rand_flit(),
                  $urandom_range(0, 99) < 50, $urandom_range(0, VC_NUM-1));
            if (i == 150) mid_cycle_reset("rst_b");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
